// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency unified memory between the debug
// loader (dbg_*), the core load/store path (d_*) and instruction fetch (if_*).
// Each access runs IDLE -> ISSUE -> WAIT (MEM_LATENCY cycles) -> DONE, and the
// owner gets a one-cycle ack in DONE together with the read data in rdata.
//
// Parameters: ADDR_W, DATA_W, MEM_LATENCY (1..8, issue cycle to mem_rdata valid).
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   dbg_req/we/addr/wdata -> dbg_ack   loader port (absolute priority)
//   d_req/we/addr/wdata   -> d_ack     load/store port
//   if_req/addr           -> if_ack    fetch port (reads only)
//   rdata               shared read-data register
//   busy, gnt_id        not-IDLE flag, in-flight owner (0 none,1 dbg,2 d,3 if)
//   mem_en/we/addr/wdata, mem_rdata    memory interface
// Optional build macro ARB_STATS_EN adds 16-bit saturating ack counters
// stat_dbg, stat_d and stat_if.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned MEM_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic [1:0]        gnt_id,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef ARB_STATS_EN
    ,
    output logic [15:0]       stat_dbg,
    output logic [15:0]       stat_d,
    output logic [15:0]       stat_if
`endif
);

    localparam int unsigned CNT_W    = 4;
    localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(MEM_LATENCY - 1);

    localparam logic [1:0] ID_NONE = 2'd0;
    localparam logic [1:0] ID_DBG  = 2'd1;
    localparam logic [1:0] ID_D    = 2'd2;
    localparam logic [1:0] ID_IF   = 2'd3;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               prefer_if_q, prefer_if_d;
    logic [1:0]         gnt_q, gnt_d;
    logic               busy_q, busy_d;
    logic               mem_en_q, mem_en_d;
    logic               mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]  mem_wdata_q, mem_wdata_d;
    logic               we_lat_q, we_lat_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic               dbg_ack_q, dbg_ack_d;
    logic               d_ack_q, d_ack_d;
    logic               if_ack_q, if_ack_d;
    logic [1:0]         win_c;

    // Arbitration winner: dbg first, then lone requester, then round-robin.
    always_comb begin
        win_c = ID_NONE;
        if (dbg_req)
            win_c = ID_DBG;
        else if (d_req && if_req)
            win_c = prefer_if_q ? ID_IF : ID_D;
        else if (d_req)
            win_c = ID_D;
        else if (if_req)
            win_c = ID_IF;
    end

    // Next-state and registered-output computation.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        prefer_if_d = prefer_if_q;
        gnt_d       = gnt_q;
        busy_d      = busy_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        we_lat_d    = we_lat_q;
        rdata_d     = rdata_q;
        dbg_ack_d   = 1'b0;
        d_ack_d     = 1'b0;
        if_ack_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (win_c != ID_NONE) begin
                    state_d  = S_ISSUE;
                    gnt_d    = win_c;
                    busy_d   = 1'b1;
                    mem_en_d = 1'b1;
                    // mem_addr/mem_wdata double as the latched copy for the access.
                    case (win_c)
                        ID_DBG: begin
                            mem_we_d    = dbg_we;
                            we_lat_d    = dbg_we;
                            mem_addr_d  = dbg_addr;
                            mem_wdata_d = dbg_wdata;
                        end
                        ID_D: begin
                            mem_we_d    = d_we;
                            we_lat_d    = d_we;
                            mem_addr_d  = d_addr;
                            mem_wdata_d = d_wdata;
                            prefer_if_d = 1'b1;
                        end
                        default: begin
                            mem_we_d    = 1'b0;
                            we_lat_d    = 1'b0;
                            mem_addr_d  = if_addr;
                            prefer_if_d = 1'b0;
                        end
                    endcase
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
                cnt_d   = '0;
            end
            S_WAIT: begin
                // Last WAIT cycle is ISSUE + MEM_LATENCY: mem_rdata is valid here.
                if (cnt_q == LAT_LAST) begin
                    state_d = S_DONE;
                    if (!we_lat_q)
                        rdata_d = mem_rdata;
                    dbg_ack_d = (gnt_q == ID_DBG);
                    d_ack_d   = (gnt_q == ID_D);
                    if_ack_d  = (gnt_q == ID_IF);
                end else begin
                    cnt_d = CNT_W'(cnt_q + 1'b1);
                end
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = ID_NONE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any access in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            prefer_if_q <= 1'b1;
            gnt_q       <= ID_NONE;
            busy_q      <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            we_lat_q    <= 1'b0;
            rdata_q     <= '0;
            dbg_ack_q   <= 1'b0;
            d_ack_q     <= 1'b0;
            if_ack_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            prefer_if_q <= prefer_if_d;
            gnt_q       <= gnt_d;
            busy_q      <= busy_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            we_lat_q    <= we_lat_d;
            rdata_q     <= rdata_d;
            dbg_ack_q   <= dbg_ack_d;
            d_ack_q     <= d_ack_d;
            if_ack_q    <= if_ack_d;
        end
    end

    assign dbg_ack   = dbg_ack_q;
    assign d_ack     = d_ack_q;
    assign if_ack    = if_ack_q;
    assign rdata     = rdata_q;
    assign busy      = busy_q;
    assign gnt_id    = gnt_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

`ifdef ARB_STATS_EN
    logic [15:0] stat_dbg_q, stat_dbg_d;
    logic [15:0] stat_d_q, stat_d_d;
    logic [15:0] stat_if_q, stat_if_d;

    // Saturating ack counters, updated in step with the ack register.
    always_comb begin
        stat_dbg_d = stat_dbg_q;
        stat_d_d   = stat_d_q;
        stat_if_d  = stat_if_q;
        if (dbg_ack_d && (stat_dbg_q != 16'hFFFF))
            stat_dbg_d = stat_dbg_q + 16'd1;
        if (d_ack_d && (stat_d_q != 16'hFFFF))
            stat_d_d = stat_d_q + 16'd1;
        if (if_ack_d && (stat_if_q != 16'hFFFF))
            stat_if_d = stat_if_q + 16'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_dbg_q <= '0;
            stat_d_q   <= '0;
            stat_if_q  <= '0;
        end else begin
            stat_dbg_q <= stat_dbg_d;
            stat_d_q   <= stat_d_d;
            stat_if_q  <= stat_if_d;
        end
    end

    assign stat_dbg = stat_dbg_q;
    assign stat_d   = stat_d_q;
    assign stat_if  = stat_if_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: a MEM_LATENCY=1 instance driven by a
// table of single transactions plus round-robin / debug-priority sequences, and
// a MEM_LATENCY=4 instance used for latency and mid-transaction reset checks.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- MEM_LATENCY = 1 instance ----------------
    logic        reset;
    logic        dbg_req, dbg_we, d_req, d_we, if_req;
    logic [31:0] dbg_addr, dbg_wdata, d_addr, d_wdata, if_addr;
    logic        dbg_ack, d_ack, if_ack, busy, mem_en, mem_we;
    logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;
    logic [1:0]  gnt_id;
`ifdef ARB_STATS_EN
    logic [15:0] stat_dbg, stat_d, stat_if;
`endif

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(1)) u_dut (
        .clk(clk), .reset(reset),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_ack(dbg_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack),
        .rdata(rdata), .busy(busy), .gnt_id(gnt_id),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
`ifdef ARB_STATS_EN
        , .stat_dbg(stat_dbg), .stat_d(stat_d), .stat_if(stat_if)
`endif
    );

    // Synchronous memory, one-cycle read latency.
    logic [31:0] mem [256];
    logic [31:0] mem_rd;
    logic        mem_init;
    always @(posedge clk) begin
        if (mem_init)
            mem[8'h10] <= 32'h00500093;
        else if (mem_en) begin
            if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
            else        mem_rd <= mem[mem_addr[7:0]];
        end
    end
    assign mem_rdata = mem_rd;

    // ---------------- MEM_LATENCY = 4 instance (fetch only) ----------------
    logic        reset4, if_req4, if_ack4, busy4, mem_en4, mem_we4;
    logic        dbg_ack4, d_ack4;
    logic [31:0] if_addr4, rdata4, mem_addr4, mem_wdata4, mem_rdata4;
    logic [31:0] zero32 = 32'h0;
    logic        zero1 = 1'b0;
    logic [1:0]  gnt_id4;
`ifdef ARB_STATS_EN
    logic [15:0] stat_dbg4, stat_d4, stat_if4;
`endif

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(4)) u_dut4 (
        .clk(clk), .reset(reset4),
        .dbg_req(zero1), .dbg_we(zero1), .dbg_addr(zero32), .dbg_wdata(zero32), .dbg_ack(dbg_ack4),
        .d_req(zero1), .d_we(zero1), .d_addr(zero32), .d_wdata(zero32), .d_ack(d_ack4),
        .if_req(if_req4), .if_addr(if_addr4), .if_ack(if_ack4),
        .rdata(rdata4), .busy(busy4), .gnt_id(gnt_id4),
        .mem_en(mem_en4), .mem_we(mem_we4), .mem_addr(mem_addr4), .mem_wdata(mem_wdata4),
        .mem_rdata(mem_rdata4)
`ifdef ARB_STATS_EN
        , .stat_dbg(stat_dbg4), .stat_d(stat_d4), .stat_if(stat_if4)
`endif
    );

    // Four-stage read pipe: data for address A is A ^ 0xA5A50000.
    logic [31:0] pipe4 [4];
    always @(posedge clk) begin
        pipe4[0] <= (mem_en4 && !mem_we4) ? (mem_addr4 ^ 32'hA5A50000) : 32'h0;
        for (int i = 1; i < 4; i++) pipe4[i] <= pipe4[i-1];
    end
    assign mem_rdata4 = pipe4[3];

    // ---------------- checking helpers ----------------
    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drop_all();
        dbg_req = 1'b0; d_req = 1'b0; if_req = 1'b0;
        dbg_we  = 1'b0; d_we  = 1'b0;
    endtask

    task automatic do_reset();
        drop_all();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    typedef struct {
        logic [2:0]  req;    // {dbg, d, if}
        logic        we;     // applied to dbg_we and d_we
        logic [31:0] a_dbg;
        logic [31:0] a_d;
        logic [31:0] a_if;
        logic [31:0] wdata;
        logic [1:0]  gnt;
        logic [31:0] addr;
        logic [31:0] rdata;
    } vec_t;

    vec_t vecs [8];

`ifdef ARB_STATS_EN
    // One complete transaction on the fetch (sel=0) or load (sel=1) port.
    task automatic run_txn(input logic sel);
        logic seen;
        seen = 1'b0;
        if (sel) begin d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10; end
        else     begin if_req = 1'b1; if_addr = 32'h10; end
        for (int c = 0; c < 12 && !seen; c++) begin
            tick();
            if (d_ack || if_ack) seen = 1'b1;
        end
        chk("stats_txn_ack", 32'(seen), 32'd1);
        tick();
        drop_all();
        tick();
    endtask
`endif

    initial begin
        logic [1:0] seq [4];
        logic [1:0] rr_exp [4];
        logic [1:0] dp_exp [4];
        logic [2:0] exp_ack;
        int ng, nack, ack4;
        logic drop_next;

        vecs[0] = '{3'b001, 1'b0, 32'h0,  32'h0,  32'h10, 32'h0,        2'd3, 32'h10, 32'h00500093};
        vecs[1] = '{3'b010, 1'b1, 32'h0,  32'h20, 32'h0,  32'hDEADBEEF, 2'd2, 32'h20, 32'h00500093};
        vecs[2] = '{3'b001, 1'b0, 32'h0,  32'h0,  32'h20, 32'h0,        2'd3, 32'h20, 32'hDEADBEEF};
        vecs[3] = '{3'b011, 1'b0, 32'h0,  32'h10, 32'h20, 32'h0,        2'd2, 32'h10, 32'h00500093};
        vecs[4] = '{3'b011, 1'b0, 32'h0,  32'h10, 32'h20, 32'h0,        2'd3, 32'h20, 32'hDEADBEEF};
        vecs[5] = '{3'b111, 1'b1, 32'h30, 32'h10, 32'h20, 32'h12345678, 2'd1, 32'h30, 32'hDEADBEEF};
        vecs[6] = '{3'b100, 1'b0, 32'h30, 32'h0,  32'h0,  32'h0,        2'd1, 32'h30, 32'h12345678};
        vecs[7] = '{3'b011, 1'b0, 32'h0,  32'h30, 32'h10, 32'h0,        2'd2, 32'h30, 32'h12345678};
        rr_exp = '{2'd3, 2'd2, 2'd3, 2'd2};
        dp_exp = '{2'd1, 2'd1, 2'd1, 2'd3};

        drop_all();
        dbg_addr = '0; dbg_wdata = '0; d_addr = '0; d_wdata = '0; if_addr = '0;
        if_req4 = 1'b0; if_addr4 = '0;
        reset = 1'b1; reset4 = 1'b1; mem_init = 1'b1;
        tick();
        tick();
        mem_init = 1'b0;
        reset = 1'b0; reset4 = 1'b0;
        tick();

        // Reset state.
        chk("rst_busy",   32'(busy), 32'd0);
        chk("rst_gnt",    32'(gnt_id), 32'd0);
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_addr",   mem_addr, 32'd0);
        chk("rst_wdata",  mem_wdata, 32'd0);
        chk("rst_rdata",  rdata, 32'd0);
        chk("rst_acks",   32'({dbg_ack, d_ack, if_ack}), 32'd0);

        // Table of single transactions (MEM_LATENCY=1, ack at N+3).
        for (int i = 0; i < 8; i++) begin
            dbg_req = vecs[i].req[2]; d_req = vecs[i].req[1]; if_req = vecs[i].req[0];
            dbg_we = vecs[i].we; d_we = vecs[i].we;
            dbg_addr = vecs[i].a_dbg; d_addr = vecs[i].a_d; if_addr = vecs[i].a_if;
            dbg_wdata = vecs[i].wdata; d_wdata = vecs[i].wdata;
            exp_ack = (vecs[i].gnt == 2'd1) ? 3'b100 : (vecs[i].gnt == 2'd2) ? 3'b010 : 3'b001;
            tick(); // N+1: ISSUE
            chk($sformatf("v%0d_mem_en", i), 32'(mem_en), 32'd1);
            chk($sformatf("v%0d_mem_we", i), 32'(mem_we), 32'(vecs[i].we));
            chk($sformatf("v%0d_mem_addr", i), mem_addr, vecs[i].addr);
            chk($sformatf("v%0d_gnt_issue", i), 32'(gnt_id), 32'(vecs[i].gnt));
            chk($sformatf("v%0d_busy_issue", i), 32'(busy), 32'd1);
            if (vecs[i].we) chk($sformatf("v%0d_mem_wdata", i), mem_wdata, vecs[i].wdata);
            tick(); // N+2: WAIT
            chk($sformatf("v%0d_ack_early", i), 32'({dbg_ack, d_ack, if_ack}), 32'd0);
            chk($sformatf("v%0d_mem_en_wait", i), 32'(mem_en), 32'd0);
            tick(); // N+3: DONE
            chk($sformatf("v%0d_ack", i), 32'({dbg_ack, d_ack, if_ack}), 32'(exp_ack));
            chk($sformatf("v%0d_rdata", i), rdata, vecs[i].rdata);
            chk($sformatf("v%0d_gnt_done", i), 32'(gnt_id), 32'(vecs[i].gnt));
            tick(); // N+4: IDLE
            chk($sformatf("v%0d_busy_idle", i), 32'(busy), 32'd0);
            chk($sformatf("v%0d_gnt_idle", i), 32'(gnt_id), 32'd0);
            chk($sformatf("v%0d_ack_clear", i), 32'({dbg_ack, d_ack, if_ack}), 32'd0);
            drop_all();
            tick();
        end

        // Round-robin with data and fetch held continuously.
        do_reset();
        d_req = 1'b1; d_addr = 32'h10; if_req = 1'b1; if_addr = 32'h20;
        ng = 0;
        for (int k = 0; k < 4; k++) seq[k] = 2'd0;
        for (int c = 0; c < 40 && ng < 4; c++) begin
            tick();
            if (mem_en) begin seq[ng] = gnt_id; ng++; end
            chk("rr_ack_onehot", 32'($countones({dbg_ack, d_ack, if_ack}) > 1), 32'd0);
        end
        chk("rr_grants_seen", 32'(ng), 32'd4);
        for (int k = 0; k < 4; k++) chk($sformatf("rr_gnt%0d", k), 32'(seq[k]), 32'(rr_exp[k]));

        // Debug priority: dbg wins while held; fetch next once it drops.
        do_reset();
        dbg_req = 1'b1; dbg_addr = 32'h30; d_req = 1'b1; if_req = 1'b1;
        ng = 0; nack = 0; drop_next = 1'b0;
        for (int k = 0; k < 4; k++) seq[k] = 2'd0;
        for (int c = 0; c < 60 && ng < 4; c++) begin
            tick();
            if (drop_next) begin dbg_req = 1'b0; drop_next = 1'b0; end
            if (mem_en) begin seq[ng] = gnt_id; ng++; end
            chk("dp_core_ack", 32'(d_ack || if_ack), 32'd0);
            if (dbg_ack) begin nack++; if (nack == 3) drop_next = 1'b1; end
        end
        chk("dp_grants_seen", 32'(ng), 32'd4);
        for (int k = 0; k < 4; k++) chk($sformatf("dp_gnt%0d", k), 32'(seq[k]), 32'(dp_exp[k]));
        do_reset();

        // MEM_LATENCY=4: reset in the second WAIT cycle aborts with no ack.
        if_req4 = 1'b1; if_addr4 = 32'h44;
        tick(); // N+1
        chk("l4_issue", 32'(mem_en4), 32'd1);
        tick(); // N+2 WAIT1
        tick(); // N+3 WAIT2
        chk("l4_busy_wait", 32'(busy4), 32'd1);
        reset4 = 1'b1;
        #1;
        chk("abort_busy",   32'(busy4), 32'd0);
        chk("abort_gnt",    32'(gnt_id4), 32'd0);
        chk("abort_mem_en", 32'(mem_en4), 32'd0);
        if_req4 = 1'b0;
        tick();
        tick();
        reset4 = 1'b0;
        ack4 = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (if_ack4 || dbg_ack4 || d_ack4) ack4++;
        end
        chk("abort_no_ack", 32'(ack4), 32'd0);

        // MEM_LATENCY=4 fetch after reset: ack exactly at N+6.
        if_req4 = 1'b1; if_addr4 = 32'h48;
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk($sformatf("l4_ack_n%0d", k), 32'(if_ack4), (k == 6) ? 32'd1 : 32'd0);
        end
        chk("l4_rdata", rdata4, 32'hA5A50048);
        tick();
        if_req4 = 1'b0;
        chk("l4_idle", 32'(busy4), 32'd0);

`ifdef ARB_STATS_EN
        // Ack counters: 3 fetches, 2 loads, then cleared by reset.
        do_reset();
        run_txn(1'b0);
        run_txn(1'b1);
        run_txn(1'b0);
        run_txn(1'b1);
        run_txn(1'b0);
        chk("stat_if",  32'(stat_if), 32'd3);
        chk("stat_d",   32'(stat_d), 32'd2);
        chk("stat_dbg", 32'(stat_dbg), 32'd0);
        do_reset();
        chk("stat_clr", 32'({stat_if, stat_d} | 32'(stat_dbg)), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
